// File: rtl/trig_pkg.sv
// Shared trigger-protocol definitions: mode byte codes, frame header, report FSM states.
// Frame length depends on TRIG_REPORT_CHECKSUM_EN (5 bytes with checksum, 4 without).
package trig_pkg;

    localparam logic [7:0] HEADER    = 8'hA5;
    localparam logic [7:0] MODE_RISE = 8'd1;
    localparam logic [7:0] MODE_FALL = 8'd2;
    localparam logic [7:0] MODE_BOTH = 8'd3;
    localparam logic [7:0] MODE_NONE = 8'd4;

`ifdef TRIG_REPORT_CHECKSUM_EN
    localparam int unsigned FRAME_LEN = 5;
`else
    localparam int unsigned FRAME_LEN = 4;
`endif
    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEND  = 3'd1,
        ST_ACK   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } trig_state_t;

endpackage

// File: rtl/trig_mode_enc.sv
// Maps the two edge-enable bits onto the protocol mode byte shared with the receiver.
module trig_mode_enc
    import trig_pkg::*;
(
    input  logic       en_rise,
    input  logic       en_fall,
    output logic [7:0] mode
);

    always_comb begin
        mode = MODE_NONE;
        case ({en_rise, en_fall})
            2'b10:   mode = MODE_RISE;
            2'b01:   mode = MODE_FALL;
            2'b11:   mode = MODE_BOTH;
            default: mode = MODE_NONE;
        endcase
    end

endmodule

// File: rtl/trig_report.sv
// Snapshots trigger settings on activate and streams them as a framed byte sequence to the UART TX.
// Optional trailing XOR checksum byte when TRIG_REPORT_CHECKSUM_EN is defined.
module trig_report
    import trig_pkg::*;
#(
    parameter logic [7:0] HEADER_VAL = HEADER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        activate,
    output logic        done,
    input  logic        en_rise,
    input  logic        en_fall,
    input  logic [7:0]  lower_bound,
    input  logic [7:0]  upper_bound,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output trig_state_t dbg_state
);

    // Handshake: tx_start is a one-cycle strobe issued only when tx_busy is low; the byte
    // is considered accepted once tx_busy has been seen high and then low again.
    trig_state_t state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic        rise_q, rise_d;
    logic        fall_q, fall_d;
    logic [7:0]  lo_q, lo_d;
    logic [7:0]  hi_q, hi_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  mode_byte;
    logic [7:0]  cur_byte;

    trig_mode_enc u_mode_enc (
        .en_rise (rise_q),
        .en_fall (fall_q),
        .mode    (mode_byte)
    );

`ifdef TRIG_REPORT_CHECKSUM_EN
    logic [7:0] csum;
    assign csum = HEADER_VAL ^ mode_byte ^ lo_q ^ hi_q;
`endif

    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            3'd0:    cur_byte = HEADER_VAL;
            3'd1:    cur_byte = mode_byte;
            3'd2:    cur_byte = lo_q;
            3'd3:    cur_byte = hi_q;
`ifdef TRIG_REPORT_CHECKSUM_EN
            3'd4:    cur_byte = csum;
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        rise_d     = rise_q;
        fall_d     = fall_q;
        lo_d       = lo_q;
        hi_d       = hi_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (activate) begin
                    rise_d  = en_rise;
                    fall_d  = en_fall;
                    lo_d    = lower_bound;
                    hi_d    = upper_bound;
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_data_d  = cur_byte;
                    tx_start_d = 1'b1;
                    state_d    = ST_ACK;
                end
            end
            ST_ACK: begin
                if (tx_busy) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!tx_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                if (!activate) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
            lo_q       <= 8'h00;
            hi_q       <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    assign done      = (state_q == ST_DONE);
    assign tx_data   = tx_data_q;
    assign tx_start  = tx_start_q;
    assign dbg_state = state_q;

endmodule
